arc4_sched: RTL and testbench
=============================

# arc4_sched

Top-level sequencer for the ARC4 datapath. It accepts one decryption request over a ready/enable handshake, then runs the init, KSA and PRGA engines in order using their own ready/enable handshakes. It also arbitrates the single-port 256×8 S memory so that exactly one engine drives the port at a time. It sits between the task-level top (switches/keys) and the three engines, replacing per-task hand wiring.

## Interface
- `KEY_W`, default 24: key width passed to KSA/PRGA.
- `ADDR_W`, default 8: S memory address width.

- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset; also fed to all three engines.
- `en`  in  1: start request, sampled only while `rdy`=1.
- `rdy`  out  1: high while idle and able to accept `en`.
- `key`  in  KEY_W: key, latched on an accepted `en`.
- `key_q`  out  KEY_W: latched key to KSA/PRGA.
- `init_en`, `ksa_en`, `prga_en`  out  1 each: one-cycle engine start pulses.
- `init_rdy`, `ksa_rdy`, `prga_rdy`  in  1 each: engine ready flags.
- `{init,ksa,prga}_addr`  in  ADDR_W: per-engine S address.
- `{init,ksa,prga}_wrdata`  in  8: per-engine S write data.
- `{init,ksa,prga}_wren`  in  1: per-engine S write enable.
- `s_addr`  out  ADDR_W: S memory address.
- `s_wrdata`  out  8: S memory write data.
- `s_wren`  out  1: S memory write enable. `s_rddata` goes straight from the memory to all engines and does not pass through this block.

## Operation
- States: IDLE, INIT_GO, INIT_BUSY, KSA_GO, KSA_BUSY, PRGA_GO, PRGA_BUSY.
- IDLE: `rdy`=1. If `en`=1, latch `key` into `key_q` and go to INIT_GO. Otherwise stay.
- X_GO: `X_en` = `X_rdy`, combinational from state.
  - If `X_rdy`=1, go to X_BUSY.
  - If `X_rdy`=0, hold in X_GO with `X_en`=0.
- X_BUSY: the first cycle is a guard cycle and ignores `X_rdy`. After that, `X_rdy`=1 advances:
  - INIT_BUSY → KSA_GO
  - KSA_BUSY → PRGA_GO
  - PRGA_BUSY → IDLE
- Memory ownership:
  - Owner is init in INIT_GO/INIT_BUSY, ksa in KSA_*, prga in PRGA_*.
  - `s_addr`/`s_wrdata`/`s_wren` come from the owner only. Non-owner `wren` has no effect.
  - In IDLE: `s_addr`=0, `s_wrdata`=0, `s_wren`=0.
- `en` while `rdy`=0 is ignored, and `key_q` is unchanged.
- `en` held high across the return to IDLE starts a new run in that same IDLE cycle.

## Timing
- Reset values: state IDLE, `rdy`=1, `key_q`=0, all `*_en`=0, `s_wren`=0, `s_addr`=0, `s_wrdata`=0.
- `en` accepted at edge t: `rdy`=0 and state INIT_GO from t+1. `init_en`=1 during t+1 if `init_rdy`=1.
- Minimum cost per phase is 3 cycles (GO + guard + one ready cycle). Minimum `en`→`rdy` latency is 9 cycles plus engine busy time.
- The memory mux is purely combinational, with zero added latency, so engines see their own timing unchanged.
- Reset mid-operation: state goes to IDLE and `rdy`=1 at the next edge. Any `en` pulse in that same cycle is dropped, and ownership is released.
- `rst` and `en` in the same cycle: `rst` wins.

## Configuration
- `ARC4_SCHED_CYCCNT_EN` defined:
  - Adds output `cyc_cnt` (32 bits).
  - Cleared to 0 on an accepted `en`. Increments every cycle while `rdy`=0, and holds in IDLE. Saturates at 32'hFFFF_FFFF.
  - Reset value 0.
- Macro undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- `arc4_pkg`:
  - `sched_state_t` enum.
  - `owner_t` enum (NONE, INIT, KSA, PRGA).
  - `ARC4_ADDR_W`, `ARC4_KEY_W` constants.
- Sub-module `s_mem_mux`: purely combinational. Selects by `owner_t` among the three engine port bundles and drives zeros for NONE.

## Test plan
- Reset, then idle 5 cycles → `rdy`=1, all `*_en`=0, `s_wren`=0, `s_addr`=0.
- Stub engines with busy times 256/768/40 cycles, `key`=24'h000311, `en` pulse:
  - each `*_en` pulses exactly once, in order;
  - `key_q`=24'h000311;
  - `rdy` returns 1 after 256+768+40+9 cycles.
- During INIT_BUSY, drive `ksa_wren`=1, `ksa_addr`=8'h55 and `init_addr`=8'h10, `init_wren`=1 → `s_addr`=8'h10, `s_wren`=1. During KSA_BUSY, `s_addr` follows `ksa_addr`.
- Hold `ksa_rdy`=0 for 10 cycles after init completes → remain in KSA_GO with `ksa_en`=0, then pulse once when `ksa_rdy` rises.
- `en`=1 with `key`=24'hABCDEF while busy → ignored, `key_q` unchanged, no restart.
- `rst` asserted mid-KSA → next cycle `rdy`=1, `s_wren`=0. With the macro defined, `cyc_cnt`=0, and a new run counts from 0.

Source files
------------

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 scheduler and its memory mux
package arc4_pkg;
    localparam int ARC4_ADDR_W = 8;
    localparam int ARC4_KEY_W  = 24;

    typedef enum logic [2:0] {
        IDLE, INIT_GO, INIT_BUSY, KSA_GO, KSA_BUSY, PRGA_GO, PRGA_BUSY
    } sched_state_t;

    typedef enum logic [1:0] {NONE, INIT, KSA, PRGA} owner_t;

    function automatic owner_t owner_of(sched_state_t s);
        return (s == INIT_GO || s == INIT_BUSY) ? INIT :
               (s == KSA_GO  || s == KSA_BUSY)  ? KSA  :
               (s == PRGA_GO || s == PRGA_BUSY) ? PRGA : NONE;
    endfunction
endpackage

// File: rtl/arc4_sched_s_mem_mux.sv
// s_mem_mux: combinational S-memory port select; the current owner drives, zeros when nobody owns it
module s_mem_mux
    import arc4_pkg::*;
#(
    parameter int ADDR_W = ARC4_ADDR_W
) (
    input  owner_t            owner,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [7:0]        init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [7:0]        ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [7:0]        prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren
);
    always_comb begin
        s_addr   = owner == INIT ? init_addr   : owner == KSA ? ksa_addr   : owner == PRGA ? prga_addr   : '0;
        s_wrdata = owner == INIT ? init_wrdata : owner == KSA ? ksa_wrdata : owner == PRGA ? prga_wrdata : '0;
        s_wren   = owner == INIT ? init_wren   : owner == KSA ? ksa_wren   : owner == PRGA ? prga_wren   : 1'b0;
    end
endmodule

// File: rtl/arc4_sched.sv
// arc4_sched: runs init -> KSA -> PRGA on one request and arbitrates the shared S memory.
// Defining ARC4_SCHED_CYCCNT_EN adds a saturating busy-cycle counter on cyc_cnt.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int KEY_W  = ARC4_KEY_W,
    parameter int ADDR_W = ARC4_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [KEY_W-1:0]  key_q,
`ifdef ARC4_SCHED_CYCCNT_EN
    output logic [31:0]       cyc_cnt,
`endif
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [7:0]        init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [7:0]        ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [7:0]        prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren
);
    sched_state_t state;
    logic         guard;

    assign rdy     = state == IDLE;
    assign init_en = state == INIT_GO && init_rdy;
    assign ksa_en  = state == KSA_GO  && ksa_rdy;
    assign prga_en = state == PRGA_GO && prga_rdy;

    // guard is high only in the first BUSY cycle, masking the engine's stale ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            key_q <= '0;
            guard <= 1'b0;
        end else begin
            guard <= state inside {INIT_GO, KSA_GO, PRGA_GO};
            case (state)
                IDLE:      if (en) begin key_q <= key; state <= INIT_GO; end
                INIT_GO:   if (init_rdy) state <= INIT_BUSY;
                INIT_BUSY: if (!guard && init_rdy) state <= KSA_GO;
                KSA_GO:    if (ksa_rdy) state <= KSA_BUSY;
                KSA_BUSY:  if (!guard && ksa_rdy) state <= PRGA_GO;
                PRGA_GO:   if (prga_rdy) state <= PRGA_BUSY;
                PRGA_BUSY: if (!guard && prga_rdy) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

`ifdef ARC4_SCHED_CYCCNT_EN
    always_ff @(posedge clk) begin
        if (rst || (rdy && en))
            cyc_cnt <= '0;
        else if (!rdy && cyc_cnt != 32'hFFFF_FFFF)
            cyc_cnt <= cyc_cnt + 32'd1;
    end
`endif

    s_mem_mux #(.ADDR_W(ADDR_W)) u_mux (
        .owner(owner_of(state)),
        .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
        .ksa_addr(ksa_addr),   .ksa_wrdata(ksa_wrdata),   .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );
endmodule

// File: tb/tb_arc4_sched.sv
// tb_arc4_sched: directed bench for arc4_sched with counting stub engines; checks cyc_cnt when
// ARC4_SCHED_CYCCNT_EN is defined.
module tb_arc4_sched;
    logic        clk = 1'b0;
    logic        rst, en, rdy;
    logic [23:0] key, key_q;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  init_addr, ksa_addr, prga_addr;
    logic [7:0]  init_wrdata, ksa_wrdata, prga_wrdata;
    logic        init_wren, ksa_wren, prga_wren;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;
    logic [31:0] cyc_cnt;
    logic        ksa_hold;
    logic [2:0]  s_rdy;
    logic [2:0]  en_v;
    int          bt[3];
    int          cnt[3];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n, p_i, p_k, p_p, t_k, t_p;

    always #5 clk = ~clk;

`ifndef ARC4_SCHED_CYCCNT_EN
    assign cyc_cnt = '0;
`endif

    arc4_sched #(.KEY_W(24), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_q(key_q),
`ifdef ARC4_SCHED_CYCCNT_EN
        .cyc_cnt(cyc_cnt),
`endif
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    // Stub engine i: ready drops on its start pulse and stays low for bt[i]+1 cycles
    assign en_v     = {prga_en, ksa_en, init_en};
    assign init_rdy = s_rdy[0];
    assign ksa_rdy  = s_rdy[1] & ~ksa_hold;
    assign prga_rdy = s_rdy[2];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                s_rdy[i] <= 1'b1;
                cnt[i]   <= 0;
            end else if (en_v[i] && s_rdy[i]) begin
                s_rdy[i] <= 1'b0;
                cnt[i]   <= bt[i];
            end else if (!s_rdy[i]) begin
                if (cnt[i] == 0) s_rdy[i] <= 1'b1;
                else cnt[i] <= cnt[i] - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; key = '0; ksa_hold = 1'b0;
        init_addr = '0; init_wrdata = '0; init_wren = 1'b0;
        ksa_addr = '0; ksa_wrdata = '0; ksa_wren = 1'b0;
        prga_addr = '0; prga_wrdata = '0; prga_wren = 1'b0;
        bt = '{2, 2, 2};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_rdy", rdy, 1);
        chk("reset_init_en", init_en, 0);
        chk("reset_ksa_en", ksa_en, 0);
        chk("reset_prga_en", prga_en, 0);
        chk("reset_s_wren", s_wren, 0);
        chk("reset_s_addr", s_addr, 0);
        chk("reset_s_wrdata", s_wrdata, 0);
        chk("reset_key_q", key_q, 0);
`ifdef ARC4_SCHED_CYCCNT_EN
        chk("reset_cyc_cnt", cyc_cnt, 0);
`endif

        // Full run with busy times 256/768/40
        bt = '{256, 768, 40};
        init_addr = 8'h10; init_wrdata = 8'hA5; init_wren = 1'b1;
        ksa_addr = 8'h55; ksa_wrdata = 8'h3C; ksa_wren = 1'b1;
        prga_addr = 8'h77; prga_wrdata = 8'h99; prga_wren = 1'b0;
        key = 24'h000311; en = 1'b1;
        @(negedge clk);
        en = 1'b0; key = '0;
        chk("run1_rdy_low", rdy, 0);
        chk("run1_init_en", init_en, 1);
        chk("run1_key_q", key_q, 24'h000311);
        chk("run1_go_s_addr", s_addr, 8'h10);
        chk("run1_go_s_wren", s_wren, 1);
`ifdef ARC4_SCHED_CYCCNT_EN
        chk("run1_cyc_start", cyc_cnt, 0);
`endif
        n = 1; p_i = 1; p_k = 0; p_p = 0; t_k = 0; t_p = 0;
        while (n < 5000) begin
            if (n == 5) begin
                chk("init_busy_s_addr", s_addr, 8'h10);
                chk("init_busy_s_wrdata", s_wrdata, 8'hA5);
                chk("init_busy_s_wren", s_wren, 1);
            end
            if (n == 100) begin en = 1'b1; key = 24'hABCDEF; end
            if (n == 101) begin en = 1'b0; key = '0; end
            if (n == 600) begin
                chk("ksa_busy_s_addr", s_addr, 8'h55);
                chk("ksa_busy_s_wrdata", s_wrdata, 8'h3C);
                chk("ksa_busy_s_wren", s_wren, 1);
            end
            if (n == 1050) begin
                chk("prga_busy_s_addr", s_addr, 8'h77);
                chk("prga_busy_s_wrdata", s_wrdata, 8'h99);
                chk("prga_busy_s_wren", s_wren, 0);
            end
            @(negedge clk);
            if (rdy) break;
            n++;
            if (init_en) p_i++;
            if (ksa_en) begin p_k++; t_k = n; end
            if (prga_en) begin p_p++; t_p = n; end
        end
        chk("run1_rdy_back", rdy, 1);
        chk("run1_busy_cycles", n, 1073);
        chk("run1_init_pulses", p_i, 1);
        chk("run1_ksa_pulses", p_k, 1);
        chk("run1_prga_pulses", p_p, 1);
        chk("run1_ksa_en_cycle", t_k, 260);
        chk("run1_prga_en_cycle", t_p, 1031);
        chk("run1_key_q_kept", key_q, 24'h000311);
        chk("run1_idle_s_addr", s_addr, 0);
        chk("run1_idle_s_wren", s_wren, 0);
`ifdef ARC4_SCHED_CYCCNT_EN
        chk("run1_cyc_end", cyc_cnt, 1073);
`endif

        // KSA held not-ready in KSA_GO, then reset mid-KSA with en in the same cycle
        bt = '{3, 4, 2};
        ksa_hold = 1'b1;
        key = 24'h0000AA; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("ksa_go_hold_en", ksa_en, 0);
            chk("ksa_go_hold_s_addr", s_addr, 8'h55);
            @(negedge clk);
        end
        ksa_hold = 1'b0;
        #1;
        chk("ksa_go_release_en", ksa_en, 1);
        @(negedge clk);
        chk("ksa_busy_en_low", ksa_en, 0);
        chk("ksa_busy_rdy", rdy, 0);
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", rdy, 1);
        chk("mid_rst_s_wren", s_wren, 0);
        chk("mid_rst_s_addr", s_addr, 0);
        chk("mid_rst_ksa_en", ksa_en, 0);
        chk("mid_rst_key_q", key_q, 0);
`ifdef ARC4_SCHED_CYCCNT_EN
        chk("mid_rst_cyc", cyc_cnt, 0);
`endif
        rst = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("rst_en_dropped_rdy", rdy, 1);
        chk("rst_en_dropped_init_en", init_en, 0);

        // Minimum-latency run with en held high across the return to IDLE
        bt = '{0, 0, 0};
        key = 24'h000123; en = 1'b1;
        @(negedge clk);
        key = 24'h000222;
        chk("run3_key_q", key_q, 24'h000123);
        chk("run3_init_en", init_en, 1);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (rdy) break;
            n++;
        end
        chk("run3_rdy_back", rdy, 1);
        chk("run3_min_latency", n, 9);
        chk("run3_key_q_held", key_q, 24'h000123);
`ifdef ARC4_SCHED_CYCCNT_EN
        chk("run3_cyc_end", cyc_cnt, 9);
`endif
        @(negedge clk);
        chk("restart_rdy", rdy, 0);
        chk("restart_key_q", key_q, 24'h000222);
        chk("restart_init_en", init_en, 1);
`ifdef ARC4_SCHED_CYCCNT_EN
        chk("restart_cyc", cyc_cnt, 0);
`endif
        en = 1'b0;
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (rdy) break;
            n++;
        end
        chk("restart_done_rdy", rdy, 1);
        chk("restart_latency", n, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
